sd_dat_tx_ctrl: RTL and testbench

- Transmit sequencer for the SD 4-bit data bus. Frames one data block per command: start bit, payload nibbles, a per-line CRC16, then the end bit.
- Drives four external per-line CRC16 units (serial LFSR, async RST, Enable-gated, CRC holds its value when Enable is low). It clears them, feeds them, then reads them back and shifts the CRCs out.
- Sits between the data FIFO (valid/ready nibble stream) and the DAT pad drivers.

---
 rtl/sd_dat_tx_ctrl_if.sv | 24 ++
 rtl/sd_dat_tx_ctrl.sv | 130 +++++++++++++
 tb/tb_sd_dat_tx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_dat_tx_ctrl_if.sv
// Bundle of the SD DAT transmit sequencer's stream, pad and CRC-unit signals.
// The master modport is the sequencer; the slave side is the FIFO, pads and CRC units.
interface sd_dat_tx_ctrl_if;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dat_out;
  logic        dat_oe;
  logic        sd_clk_en;
  logic [3:0]  crc_bit;
  logic        crc_en;
  logic        crc_clr;
  logic [63:0] crc_val;

  modport master (
    input  in_data, in_valid, crc_val,
    output in_ready, dat_out, dat_oe, sd_clk_en, crc_bit, crc_en, crc_clr
  );

  modport slave (
    output in_data, in_valid, crc_val,
    input  in_ready, dat_out, dat_oe, sd_clk_en, crc_bit, crc_en, crc_clr
  );
endinterface

// File: rtl/sd_dat_tx_ctrl.sv
// SD 4-bit DAT transmit sequencer: start bit, payload nibbles, per-line CRC16, end bit.
// The four CRC16 units live outside; this block clears, feeds and then shifts them out.
module sd_dat_tx_ctrl #(
  parameter int BLK_W = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [BLK_W-1:0] blk_len,
  output logic             busy,
  output logic             done,
  sd_dat_tx_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, CRC, END} state_t;

  localparam logic [BLK_W:0] CNT_ONE  = (BLK_W + 1)'(1);
  localparam logic [4:0]     CRC_BITS = 5'd16;

  state_t           state, state_n;
  logic [BLK_W:0]   cnt, cnt_n;
  logic [4:0]       bitcnt, bitcnt_n;
  logic [63:0]      shreg, shreg_n, crc_src;
  logic [3:0]       dat_out_n;
  logic             dat_oe_n, sd_clk_en_n, done_n, crc_clr_n;

  assign busy         = (state != IDLE);
  assign bus.in_ready = (state == DATA);
  assign bus.crc_bit  = bus.in_data;
  assign bus.crc_en   = bus.in_valid & (state == DATA);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bitcnt_n    = bitcnt;
    shreg_n     = shreg;
    dat_out_n   = bus.dat_out;
    dat_oe_n    = bus.dat_oe;
    sd_clk_en_n = 1'b0;
    done_n      = 1'b0;
    crc_clr_n   = 1'b0;
    // First CRC bit comes straight from the units; later bits from the shifted copy.
    crc_src     = (bitcnt == '0) ? bus.crc_val : shreg;

    unique case (state)
      IDLE: begin
        dat_out_n = 4'hF;
        dat_oe_n  = 1'b0;
        if (start && !abort) begin
          state_n     = START;
          cnt_n       = {blk_len, 1'b0};
          bitcnt_n    = '0;
          dat_out_n   = 4'h0;
          dat_oe_n    = 1'b1;
          sd_clk_en_n = 1'b1;
          crc_clr_n   = 1'b1;
        end
      end
      START: begin
        state_n = (cnt == '0) ? CRC : DATA;
      end
      DATA: begin
        if (bus.in_valid) begin
          dat_out_n   = bus.in_data;
          sd_clk_en_n = 1'b1;
          cnt_n       = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_n = CRC;
        end
      end
      CRC: begin
        sd_clk_en_n = 1'b1;
        if (bitcnt == CRC_BITS) begin
          dat_out_n = 4'hF;
          state_n   = END;
        end else begin
          for (int i = 0; i < 4; i++) begin
            dat_out_n[i]         = crc_src[16*i+15];
            shreg_n[16*i +: 16]  = {crc_src[16*i +: 15], 1'b0};
          end
          bitcnt_n = bitcnt + 5'd1;
        end
      end
      END: begin
        dat_out_n = 4'hF;
        dat_oe_n  = 1'b0;
        done_n    = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Abort wins over everything and re-clears the CRC units for the next block.
    if (abort && state != IDLE) begin
      state_n     = IDLE;
      cnt_n       = '0;
      bitcnt_n    = '0;
      dat_out_n   = 4'hF;
      dat_oe_n    = 1'b0;
      sd_clk_en_n = 1'b0;
      done_n      = 1'b0;
      crc_clr_n   = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      bitcnt        <= '0;
      shreg         <= '0;
      bus.dat_out   <= 4'hF;
      bus.dat_oe    <= 1'b0;
      bus.sd_clk_en <= 1'b0;
      bus.crc_clr   <= 1'b1;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bitcnt        <= bitcnt_n;
      shreg         <= shreg_n;
      bus.dat_out   <= dat_out_n;
      bus.dat_oe    <= dat_oe_n;
      bus.sd_clk_en <= sd_clk_en_n;
      bus.crc_clr   <= crc_clr_n;
      done          <= done_n;
    end
  end

endmodule

// File: tb/tb_sd_dat_tx_ctrl.sv
// Self-checking bench for sd_dat_tx_ctrl: random blocks with stalls, aborts and resets,
// compared against a frame model whose CRCs come from polynomial division.
module tb_sd_dat_tx_ctrl;
  localparam int BLK_W = 12;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [BLK_W-1:0] blk_len = '0;
  logic             busy;
  logic             done;

  sd_dat_tx_ctrl_if bus ();

  sd_dat_tx_ctrl #(.BLK_W(BLK_W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .abort   (abort),
    .blk_len (blk_len),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  // Four serial CCITT CRC16 units on the DAT lines, cleared asynchronously by crc_clr.
  logic [15:0] crcReg [4];
  always @(posedge CLK or posedge bus.crc_clr) begin
    if (bus.crc_clr) begin
      for (int i = 0; i < 4; i++) crcReg[i] <= '0;
    end else if (bus.crc_en) begin
      for (int i = 0; i < 4; i++)
        crcReg[i] <= {crcReg[i][14:0], 1'b0} ^
                     ((crcReg[i][15] ^ bus.crc_bit[i]) ? 16'h1021 : 16'h0000);
    end
  end
  assign bus.crc_val = {crcReg[3], crcReg[2], crcReg[1], crcReg[0]};

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
  end

  int          checkCount = 0;
  int          passCount  = 0;
  int          cyc        = 0;
  int          hsCount    = 0;
  int          crcEnBad   = 0;
  int          oeBad      = 0;
  int          doneCount  = 0;
  int          doneEdge   = 0;
  logic [3:0]  capAll [$];
  logic [3:0]  payload [$];
  logic [3:0]  prevFrame [$];
  logic [3:0]  lastFrame [$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.sd_clk_en) begin
      capAll.push_back(bus.dat_out);
      if (!bus.dat_oe) oeBad++;
    end
    if (bus.in_valid && bus.in_ready) hsCount++;
    if (bus.crc_en !== (bus.in_valid && bus.in_ready)) crcEnBad++;
    if (done) begin
      doneCount++;
      doneEdge = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // CRC of one line as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] crcRef(input int line);
    logic [16:0] rem;
    logic        b;
    rem = '0;
    for (int k = 0; k < payload.size() + 16; k++) begin
      b   = (k < payload.size()) ? payload[k][line] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic applyStimulus(input int n, input int stallPct, input bit newData,
                               input int abortAt, input int holdStart);
    int          idx, cycles, budget, hs0, bad0, oe0, done0, capStart, nBad;
    bit          aborted;
    logic [15:0] crcExp [4];
    logic [15:0] crcObs;
    logic [3:0]  expFrame [$];
    logic [3:0]  cap [$];
    logic [3:0]  nib;

    if (newData) begin
      payload.delete();
      for (int k = 0; k < 2 * n; k++) payload.push_back(4'($urandom_range(0, 15)));
    end
    hs0 = hsCount; bad0 = crcEnBad; oe0 = oeBad; done0 = doneCount;
    capStart = capAll.size();
    start   = 1'b1;
    blk_len = BLK_W'(n);
    @(posedge CLK); #1;
    begin
      int edge0;
      edge0   = cyc;
      idx     = 0;
      cycles  = 0;
      aborted = 1'b0;
      budget  = 8 * n + 200;
      while (doneCount == done0 && cycles < budget && !aborted) begin
        if (cycles >= holdStart) start = 1'b0;
        else blk_len = BLK_W'($urandom);
        if (abortAt >= 0 && idx == abortAt) begin
          abort = 1'b1;
          bus.in_valid = 1'b0;
          @(posedge CLK); #1;
          abort   = 1'b0;
          aborted = 1'b1;
          checkOutput("abort_dat_oe", 64'(bus.dat_oe), 64'(0));
          checkOutput("abort_busy", 64'(busy), 64'(0));
          checkOutput("abort_dat_out", 64'(bus.dat_out), 64'(4'hF));
          checkOutput("abort_crc_clr", 64'(bus.crc_clr), 64'(1));
        end else begin
          if (idx < 2 * n && $urandom_range(0, 99) >= stallPct) begin
            bus.in_valid = 1'b1;
            bus.in_data  = payload[idx];
          end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = 4'($urandom_range(0, 15));
          end
          @(negedge CLK);
          if (bus.in_valid && bus.in_ready) idx++;
          @(posedge CLK); #1;
          cycles++;
        end
      end
      bus.in_valid = 1'b0;
      start = 1'b0;

      if (aborted) begin
        @(posedge CLK); #1;
        checkOutput("abort_crc_clr_pulse", 64'(bus.crc_clr), 64'(0));
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("abort_no_done", 64'(doneCount - done0), 64'(0));
      end else begin
        checkOutput("done_seen", 64'(doneCount != done0), 64'(1));
        if (stallPct == 0)
          checkOutput("done_latency", 64'(doneEdge - edge0), 64'(2 * n + 19));
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("done_once", 64'(doneCount - done0), 64'(1));
        checkOutput("idle_dat_oe", 64'(bus.dat_oe), 64'(0));
        checkOutput("idle_busy", 64'(busy), 64'(0));
        checkOutput("idle_dat_out", 64'(bus.dat_out), 64'(4'hF));
        checkOutput("handshakes", 64'(hsCount - hs0), 64'(2 * n));
        checkOutput("crc_en_consistent", 64'(crcEnBad - bad0), 64'(0));
        checkOutput("oe_during_bits", 64'(oeBad - oe0), 64'(0));

        for (int i = 0; i < 4; i++) crcExp[i] = crcRef(i);
        expFrame.push_back(4'h0);
        for (int k = 0; k < payload.size(); k++) expFrame.push_back(payload[k]);
        for (int b = 15; b >= 0; b--) begin
          for (int i = 0; i < 4; i++) nib[i] = crcExp[i][b];
          expFrame.push_back(nib);
        end
        expFrame.push_back(4'hF);

        for (int k = capStart; k < capAll.size(); k++) cap.push_back(capAll[k]);
        checkOutput("frame_len", 64'(cap.size()), 64'(expFrame.size()));
        nBad = 0;
        for (int k = 0; k < expFrame.size(); k++)
          if (k >= cap.size() || cap[k] !== expFrame[k]) nBad++;
        checkOutput("frame_bits", 64'(nBad), 64'(0));
        if (cap.size() >= 2 * n + 18) begin
          for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) crcObs[15-k] = cap[1 + 2*n + k][i];
            checkOutput($sformatf("crc_line%0d", i), 64'(crcObs), 64'(crcExp[i]));
          end
        end
        lastFrame = cap;
      end
    end
  endtask

  initial begin
    int rstBusy, idx;

    #1 RST = 1'b1;
    #1;
    checkOutput("rst_dat_out", 64'(bus.dat_out), 64'(4'hF));
    checkOutput("rst_dat_oe", 64'(bus.dat_oe), 64'(0));
    checkOutput("rst_sd_clk_en", 64'(bus.sd_clk_en), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_crc_clr", 64'(bus.crc_clr), 64'(1));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(0));
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    checkOutput("crc_clr_held", 64'(bus.crc_clr), 64'(1));
    @(posedge CLK); #1;
    checkOutput("crc_clr_release", 64'(bus.crc_clr), 64'(0));

    start = 1'b1; abort = 1'b1;
    @(posedge CLK); #1;
    checkOutput("start_abort_ignored", 64'(busy), 64'(0));
    start = 1'b0; abort = 1'b0;
    @(posedge CLK); #1;

    $display("[TB] blk_len=1, nibbles F,F");
    payload.delete();
    payload.push_back(4'hF);
    payload.push_back(4'hF);
    applyStimulus(1, 0, 1'b0, -1, 0);

    $display("[TB] blk_len=0");
    applyStimulus(0, 0, 1'b1, -1, 0);

    $display("[TB] blk_len=512 random, start held while busy");
    applyStimulus(512, 0, 1'b1, -1, 6);
    prevFrame = lastFrame;

    $display("[TB] same block with stalls");
    applyStimulus(512, 35, 1'b0, -1, 0);
    checkOutput("stall_same_sequence", 64'(lastFrame == prevFrame), 64'(1));

    $display("[TB] abort after 10 nibbles, then a fresh block");
    applyStimulus(20, 0, 1'b1, 10, 0);
    applyStimulus(5, 20, 1'b1, -1, 0);

    $display("[TB] async reset mid-CRC with start held");
    payload.delete();
    for (int k = 0; k < 4; k++) payload.push_back(4'($urandom_range(0, 15)));
    start = 1'b1; blk_len = BLK_W'(2); idx = 0;
    @(posedge CLK); #1;
    for (int c = 0; c < 10; c++) begin
      if (idx < 4) begin
        bus.in_valid = 1'b1;
        bus.in_data  = payload[idx];
      end else bus.in_valid = 1'b0;
      @(negedge CLK);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("pre_reset_busy", 64'(busy), 64'(1));
    #2 RST = 1'b1;
    #1;
    checkOutput("async_rst_dat_out", 64'(bus.dat_out), 64'(4'hF));
    checkOutput("async_rst_dat_oe", 64'(bus.dat_oe), 64'(0));
    checkOutput("async_rst_sd_clk_en", 64'(bus.sd_clk_en), 64'(0));
    checkOutput("async_rst_busy", 64'(busy), 64'(0));
    checkOutput("async_rst_crc_clr", 64'(bus.crc_clr), 64'(1));
    rstBusy = 0;
    repeat (3) begin
      @(negedge CLK);
      if (busy) rstBusy++;
    end
    checkOutput("no_start_in_reset", 64'(rstBusy), 64'(0));
    @(posedge CLK); #1 RST = 1'b0;
    applyStimulus(3, 0, 1'b1, -1, 1);

    $display("[TB] maximum blk_len");
    applyStimulus((1 << BLK_W) - 1, 0, 1'b1, -1, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
